// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Shares one single-port memory between instruction fetch (IF)   |
// |            and data load/store (D), one transaction outstanding at a time.|
// | Options  : MEM_ARB_STARVE_GUARD_EN - forces IF to win after STARVE_MAX    |
// |            consecutive contested losses.                                  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  localparam int c_CW = (LAT > 1) ? $clog2(LAT) : 1;

  if (LAT < 1 || LAT > 4 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_arbiter: LAT must be 1..4 and STARVE_MAX at least 1");
  end

  logic [1:0]      r_state;
  logic            r_owner_d;
  logic            r_we;
  logic [c_CW-1:0] r_lat_cnt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_d_rdata;
  logic            w_pick_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int c_SW = $clog2(STARVE_MAX + 1);

  logic [c_SW-1:0] r_starve;
  logic            w_force_if;

  assign w_force_if = if_req & d_req & (r_starve == c_SW'(STARVE_MAX));
  assign w_pick_d   = d_req & ~w_force_if;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (r_state == c_IDLE && (if_req || d_req)) begin
      if (!w_pick_d)
        r_starve <= '0;
      else if (if_req)
        r_starve <= r_starve + c_SW'(1);
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_lat_cnt  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (if_req || d_req) begin
            r_owner_d <= w_pick_d;
            r_addr    <= w_pick_d ? d_addr : if_addr;
            r_we      <= w_pick_d & d_we;
            // IF carries no write data, so the last store word stays on m_wdata
            if (w_pick_d)
              r_wdata <= d_wdata;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (r_we) begin
            r_state <= c_IDLE;
          end else begin
            // WAIT always spans LAT cycles so the capture lands on valid m_rdata
            r_lat_cnt <= c_CW'(LAT - 1);
            r_state   <= c_WAIT;
          end
        end
        c_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_owner_d)
              r_d_rdata <= m_rdata;
            else
              r_if_rdata <= m_rdata;
            r_state <= c_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - c_CW'(1);
          end
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign m_en      = (r_state == c_ISSUE);
  assign m_we      = m_en & r_we;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign if_gnt    = m_en & ~r_owner_d;
  assign d_gnt     = m_en & r_owner_d;
  assign if_rvalid = (r_state == c_RESP) & ~r_owner_d;
  assign d_rvalid  = (r_state == c_RESP) & r_owner_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Random requesters and memory against a transaction-level model |
// |            of the arbiter, checked by a scoreboard monitor.               |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int LAT        = 2;
  localparam int STARVE_MAX = 4;
  localparam int NCYC       = 3000;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return (a & 32'hFFFF_FFC0) | {26'd0, 4'($urandom_range(15)), 2'b00};
  endfunction

  // Physical memory seen by the DUT: 16 words, read data valid LAT cycles after m_en
  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] pipe [LAT];
  logic          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (m_en && m_we) begin
      mem_arr[m_addr[5:2]] <= m_wdata;
    end
    pipe[0] <= (m_en === 1'b1 && m_we === 1'b0) ? mem_arr[m_addr[5:2]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign m_rdata = pipe[LAT-1];

  // Scoreboard state
  typedef struct {
    int            cyc;
    bit            is_d;
    bit            is_gnt;
    bit            we;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           evq[$];
  int            cyc     = 0;
  int            free_at = 0;
  int            arb_cyc = -100;
  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] exp_addr    = '0;
  logic [DW-1:0] exp_wdata   = '0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration happens when the memory is free; every grant
  // and read response is scheduled at an absolute cycle number.
  initial begin
    logic [DW-1:0] ref_mem [16];
    int            starve;
    bit            pick_d;
    logic [AW-1:0] addr;
    ev_t           e;
    starve = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) begin
        evq.delete();
        free_at      = cyc + 1;
        starve       = 0;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
      end else if (cyc >= free_at && (if_req || d_req)) begin
        pick_d = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (if_req && d_req) begin
          if (starve == STARVE_MAX) begin
            pick_d = 1'b0;
            starve = 0;
          end else begin
            starve++;
          end
        end else if (if_req) begin
          starve = 0;
        end
`endif
        addr     = pick_d ? d_addr : if_addr;
        exp_addr = addr;
        if (pick_d) exp_wdata = d_wdata;
        e.cyc = cyc + 1; e.is_d = pick_d; e.is_gnt = 1'b1;
        e.we = pick_d && d_we; e.data = '0;
        evq.push_back(e);
        if (pick_d && d_we) begin
          ref_mem[addr[5:2]] = d_wdata;
          free_at = cyc + 2;
        end else begin
          e.cyc = cyc + 2 + LAT; e.is_gnt = 1'b0; e.we = 1'b0;
          e.data = ref_mem[addr[5:2]];
          evq.push_back(e);
          free_at = cyc + 3 + LAT;
        end
        arb_cyc = cyc;
      end
      cyc++;
    end
  end

  // Monitor: compares the DUT against the scheduled events every cycle
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        if (e.is_gnt) begin
          chk(e.is_d ? "d_grant" : "if_grant",
              {58'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, m_we},
              {58'd0, !e.is_d, e.is_d, 1'b0, 1'b0, 1'b1, e.we});
        end else begin
          if (e.is_d) exp_d_rdata = e.data;
          else        exp_if_rdata = e.data;
          chk(e.is_d ? "d_rvalid" : "if_rvalid",
              {58'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, m_we},
              {58'd0, 1'b0, 1'b0, !e.is_d, e.is_d, 1'b0, 1'b0});
        end
      end else begin
        chk("quiet_strobes", {58'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, m_we}, 64'd0);
      end
      chk("m_addr",   {32'd0, m_addr},   {32'd0, exp_addr});
      chk("m_wdata",  {32'd0, m_wdata},  {32'd0, exp_wdata});
      chk("if_rdata", {32'd0, if_rdata}, {32'd0, exp_if_rdata});
      chk("d_rdata",  {32'd0, d_rdata},  {32'd0, exp_d_rdata});
      chk("busy",     {63'd0, busy},     {63'd0, (cyc > arb_cyc && cyc < free_at)});
    end
  end

  // Stimulus: requesters hold req until granted, then optionally re-request
  initial begin
    bit ig, dg;
    int p_if, p_d, p_st, p_rst, rst_left;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h10; d_addr = 32'h20; d_wdata = '0;
    rst_left = 2;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      ig = if_gnt; dg = d_gnt;
      @(posedge clk);
      #1;
      if (k < 1500)      begin p_if = 50;  p_d = 40;  p_st = 50; p_rst = 1; end
      else if (k < 2500) begin p_if = 100; p_d = 100; p_st = 80; p_rst = 0; end
      else               begin p_if = 40;  p_d = 30;  p_st = 30; p_rst = 4; end
      if (rst_left > 0) begin
        rst = 1'b0;
        rst_left--;
      end else if ($urandom_range(199) < p_rst) begin
        rst = 1'b0;
        rst_left = $urandom_range(2);
      end else begin
        rst = 1'b1;
      end
      if (!if_req || ig) begin
        if_req  = ($urandom_range(99) < p_if);
        if_addr = rnd_addr();
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(99) < p_d);
        d_we    = ($urandom_range(99) < p_st);
        d_addr  = rnd_addr();
        d_wdata = $urandom;
      end
    end
    @(negedge clk);
    ig = if_gnt; dg = d_gnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    if (ig) if_req = 1'b0;
    if (dg) d_req = 1'b0;
    // Let outstanding requests finish, then go quiet
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ig = if_gnt; dg = d_gnt;
      @(posedge clk);
      #1;
      if (ig) if_req = 1'b0;
      if (dg) d_req = 1'b0;
    end
    repeat (LAT + 8) @(posedge clk);
    @(negedge clk);
    #1;
    chk("requests_drained", {62'd0, if_req, d_req}, 64'd0);
    chk("events_drained", 64'(evq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
